// File: rtl/nios_system_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt aggregator.
// master drives address/strobes/writedata; slave returns readdata.
interface nios_system_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_system_irq_ctrl.sv
// Interrupt aggregator: edge/level pending, mask, priority NEXT, holdoff.
// Ports: clk, reset_n, bus (Avalon-MM slave), irq_in[NUM_SRC], irq.
module nios_system_irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios_system_irq_ctrl_if.slave  bus,
  input  logic [NUM_SRC-1:0]     irq_in,
  output logic                   irq
);

  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_MASK  = 3'd1;
  localparam logic [2:0] A_MODE  = 3'd2;
  localparam logic [2:0] A_RAW   = 3'd3;
  localparam logic [2:0] A_NEXT  = 3'd4;
  localparam logic [2:0] A_HOLD  = 3'd5;
  localparam logic [2:0] A_SWSET = 3'd6;
  localparam logic [2:0] A_CTRL  = 3'd7;

  logic [15:0]        readdata_q, readdata_d;
  logic               irq_q, irq_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] irq_in_d_q;
  logic [15:0]        hold_reg_q, hold_reg_d;
  logic [15:0]        hold_cnt_q, hold_cnt_d;
  logic               gen_q, gen_d;

  logic               wr;
  logic [NUM_SRC-1:0] wbits;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] set_v;
  logic [NUM_SRC-1:0] clr_v;
  logic [NUM_SRC-1:0] active;
  logic               ack;
  logic               nxt_valid;
  logic [3:0]         nxt_idx;
  logic               hold_act;

  assign wr    = bus.chipselect & ~bus.write_n;
  assign wbits = bus.writedata[NUM_SRC-1:0];
  assign rise  = irq_in & ~irq_in_d_q;

  assign active    = pending_q & mask_q;
  assign nxt_valid = |active;
  assign hold_act  = (hold_cnt_q != 16'd0);

  // Lowest-numbered active source wins.
  always_comb begin
    nxt_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) nxt_idx = 4'(i);
    end
  end

  always_comb begin
    mask_d     = mask_q;
    mode_d     = mode_q;
    hold_reg_d = hold_reg_q;
    gen_d      = gen_q;
    set_v      = (mode_q & rise) | (~mode_q & irq_in);
    clr_v      = '0;
    ack        = 1'b0;
    if (wr) begin
      unique case (bus.address)
        A_PEND: begin
          clr_v = wbits;
          // Ack only if a set, enabled bit is targeted.
          ack   = |(wbits & active);
        end
        A_MASK:  mask_d     = wbits;
        A_MODE:  mode_d     = wbits;
        A_HOLD:  hold_reg_d = bus.writedata;
        A_SWSET: set_v      = set_v | wbits;
        A_CTRL:  gen_d      = bus.writedata[0];
        default: ;
      endcase
    end
    // Set beats a simultaneous clear.
    pending_d = set_v | (pending_q & ~clr_v);
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (ack) begin
      hold_cnt_d = hold_reg_q;
    end else if (hold_act) begin
      hold_cnt_d = hold_cnt_q - 16'd1;
    end
  end

  assign irq_d = gen_q & nxt_valid & ~hold_act;

  always_comb begin
    readdata_d = 16'd0;
    unique case (bus.address)
      A_PEND:  readdata_d = 16'(pending_q);
      A_MASK:  readdata_d = 16'(mask_q);
      A_MODE:  readdata_d = 16'(mode_q);
      A_RAW:   readdata_d = 16'(irq_in);
      A_NEXT:  readdata_d = {nxt_valid, 11'd0, nxt_idx};
      A_HOLD:  readdata_d = hold_reg_q;
      A_SWSET: readdata_d = 16'd0;
      A_CTRL:  readdata_d = {14'd0, hold_act, gen_q};
      default: readdata_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
      pending_q  <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      irq_in_d_q <= '0;
      hold_reg_q <= '0;
      hold_cnt_q <= '0;
      gen_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      irq_in_d_q <= irq_in;
      hold_reg_q <= hold_reg_d;
      hold_cnt_q <= hold_cnt_d;
      gen_q      <= gen_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_nios_system_irq_ctrl.sv
// Directed bench for nios_system_irq_ctrl.
// Drives on negedge, samples on negedge after the active edge.
module tb_nios_system_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       irq;
  int         tests = 0;
  int         fails = 0;

  nios_system_irq_ctrl_if bus();

  nios_system_irq_ctrl #(.NUM_SRC(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic pulse0();
    @(negedge clk);
    irq_in = 8'h01;
    @(negedge clk);
    irq_in = 8'h00;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    irq_in         = 8'h01;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 16'h0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.readdata !== 16'h0) begin
      fails++;
      $display("FAIL rst_rd got %h exp 0000", bus.readdata);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL rst_irq got %b exp 0", irq);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.readdata !== 16'h0) begin
      fails++;
      $display("FAIL rst_rd1 got %h exp 0000", bus.readdata);
    end
    @(negedge clk);
    tests++;
    if (bus.readdata !== 16'h0001) begin
      fails++;
      $display("FAIL rst_rd2 got %h exp 0001", bus.readdata);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL rst_irq_gen0 got %b exp 0", irq);
    end
    irq_in = 8'h00;
    wr(3'd0, 16'h00FF);
  endtask

  task automatic test_edge();
    logic [15:0] d;
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    wr(3'd7, 16'h0001);
    pulse0();
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL edge_irq1 got %b exp 0", irq);
    end
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL edge_irq2 got %b exp 1", irq);
    end
    wr(3'd0, 16'h0001);
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL edge_ack got %b exp 0", irq);
    end
    rd(3'd0, d);
    tests++;
    if (d !== 16'h0000) begin
      fails++;
      $display("FAIL edge_pend got %h exp 0000", d);
    end
  endtask

  task automatic test_level();
    logic [15:0] d;
    wr(3'd2, 16'h0000);
    @(negedge clk);
    irq_in = 8'h01;
    repeat (2) @(negedge clk);
    wr(3'd0, 16'h0001);
    rd(3'd0, d);
    tests++;
    if (d !== 16'h0001) begin
      fails++;
      $display("FAIL lvl_pend got %h exp 0001", d);
    end
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL lvl_irq got %b exp 1", irq);
    end
    irq_in = 8'h00;
    wr(3'd0, 16'h0001);
    rd(3'd0, d);
    tests++;
    if (d !== 16'h0000) begin
      fails++;
      $display("FAIL lvl_clr got %h exp 0000", d);
    end
  endtask

  task automatic test_priority();
    logic [15:0] d;
    wr(3'd1, 16'h000C);
    wr(3'd6, 16'h000E);
    rd(3'd4, d);
    tests++;
    if (d !== 16'h8002) begin
      fails++;
      $display("FAIL next_a got %h exp 8002", d);
    end
    wr(3'd0, 16'h0004);
    rd(3'd4, d);
    tests++;
    if (d !== 16'h8003) begin
      fails++;
      $display("FAIL next_b got %h exp 8003", d);
    end
    wr(3'd0, 16'h0008);
    rd(3'd4, d);
    tests++;
    if (d !== 16'h0000) begin
      fails++;
      $display("FAIL next_c got %h exp 0000", d);
    end
    rd(3'd0, d);
    tests++;
    if (d !== 16'h0002) begin
      fails++;
      $display("FAIL prio_pend got %h exp 0002", d);
    end
    rd(3'd6, d);
    tests++;
    if (d !== 16'h0000) begin
      fails++;
      $display("FAIL swset_rd got %h exp 0000", d);
    end
    wr(3'd0, 16'h00FF);
    wr(3'd1, 16'hFFFF);
    rd(3'd1, d);
    tests++;
    if (d !== 16'h00FF) begin
      fails++;
      $display("FAIL mask_wide got %h exp 00ff", d);
    end
    irq_in = 8'hA5;
    rd(3'd3, d);
    tests++;
    if (d !== 16'h00A5) begin
      fails++;
      $display("FAIL raw got %h exp 00a5", d);
    end
    irq_in = 8'h00;
    wr(3'd1, 16'h0000);
    wr(3'd0, 16'h00FF);
  endtask

  task automatic test_holdoff();
    logic [15:0] d;
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    wr(3'd5, 16'd10);
    rd(3'd5, d);
    tests++;
    if (d !== 16'h000A) begin
      fails++;
      $display("FAIL hold_rd got %h exp 000a", d);
    end
    pulse0();
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL hold_pre got %b exp 1", irq);
    end
    @(negedge clk);
    bus.address    = 3'd0;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 16'h0001;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd7;
    irq_in         = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      irq_in = 8'h00;
      tests++;
      if (irq !== 1'b0) begin
        fails++;
        $display("FAIL hold_irq c%0d got %b exp 0", k, irq);
      end
      tests++;
      if (bus.readdata !== 16'h0003) begin
        fails++;
        $display("FAIL hold_ctl c%0d got %h exp 0003", k, bus.readdata);
      end
    end
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL hold_end got %b exp 1", irq);
    end
    tests++;
    if (bus.readdata !== 16'h0001) begin
      fails++;
      $display("FAIL hold_ctl_end got %h exp 0001", bus.readdata);
    end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    wr(3'd1, 16'h0000);
    wr(3'd0, 16'h00FF);
    wr(3'd2, 16'h0003);
    wr(3'd1, 16'h0001);
    @(negedge clk);
    bus.address    = 3'd0;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 16'h0002;
    irq_in         = 8'h02;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    irq_in         = 8'h00;
    rd(3'd0, d);
    tests++;
    if (d !== 16'h0002) begin
      fails++;
      $display("FAIL coll_pend got %h exp 0002", d);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL coll_irq got %b exp 0", irq);
    end
    wr(3'd0, 16'h0002);
    rd(3'd7, d);
    tests++;
    if (d !== 16'h0001) begin
      fails++;
      $display("FAIL coll_ctl got %h exp 0001", d);
    end
    rd(3'd0, d);
    tests++;
    if (d !== 16'h0000) begin
      fails++;
      $display("FAIL coll_clr got %h exp 0000", d);
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_priority();
    test_holdoff();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nios_system_irq_ctrl.md
Name: nios_system_irq_ctrl

Overview:
- Avalon-MM slave interrupt aggregator that sits directly downstream of nios_system_timer and the other peripheral irq outputs, and feeds a single irq line to the Nios II CPU.
- Latches per-source events as edge- or level-triggered pending bits and applies a per-source mask and a global enable.
- Provides a priority-encoded "next source" register and a programmable post-acknowledge holdoff that rate-limits CPU interrupts.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..15); bit i of irq_in is source i.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  word register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  input  16  write data.
- readdata  output  16  registered read data.
- irq_in  input  NUM_SRC  source interrupt lines, synchronous to clk, active high.
- irq  output  1  registered interrupt to CPU, active high.

Behaviour:
- Reset: readdata=0, irq=0, pending=0, mask=0, mode=0 (all sources level), irq_in_d=0, holdoff_reg=0, holdoff_cnt=0, global_en=0.
- Bits at or above NUM_SRC in any register read 0, and writes to them are ignored.
- Register map (word address):
  - 0 PENDING: R returns pending; W is write-1-to-clear.
  - 1 MASK: RW; 1=enabled.
  - 2 MODE: RW; 1=edge, 0=level.
  - 3 RAW: R returns irq_in; writes ignored.
  - 4 NEXT: R returns {valid in bit15, 0s, index in bits 3:0}; writes ignored.
  - 5 HOLDOFF: RW, 16-bit cycle count.
  - 6 SWSET: W-1-to-set pending bits; reads 0.
  - 7 CONTROL: bit0 global_en (RW); bit1 holdoff_active (R, equals holdoff_cnt!=0).
- Read latency: readdata <= mux(address) every cycle, independent of chipselect. Data therefore appears one cycle after address is presented. Unused addresses return 0.
- Edge detect: irq_in_d <= irq_in each cycle; rise = irq_in & ~irq_in_d. A source held high when reset deasserts produces a rise on the first clock after reset.
- Pending update per bit i, each cycle:
  - set_i = (mode_i ? rise_i : irq_in_i) | swset_write_i.
  - clr_i = pending_write & writedata_i.
  - pending_i <= set_i ? 1 : (clr_i ? 0 : pending_i). Set wins over a simultaneous clear.
  - Level-mode consequence: a cleared bit re-sets on the next cycle while irq_in_i remains high.
- Mode change does not alter pending; it affects only subsequent set evaluation.
- NEXT: active = pending & mask. valid = |active. index = lowest set bit of active (source 0 is highest priority). index=0 when valid=0. Combinational from current registers; registered only through readdata.
- Holdoff:
  - A PENDING write that clears at least one currently-set, masked bit is an ack. On an ack, holdoff_cnt <= holdoff_reg.
  - Otherwise holdoff_cnt decrements when nonzero and saturates at 0.
  - holdoff_reg=0 disables suppression.
  - Writing HOLDOFF mid-count does not change the running count.
  - A new ack mid-count reloads the counter.
- irq <= global_en & valid & (holdoff_cnt==0), registered. irq is therefore one cycle behind the state that causes it.
- Simultaneous writes are impossible (single port); simultaneous source events on multiple bits are all captured in the same cycle.

Test Plan:
- Reset release with irq_in=0x01, MODE=0: PENDING reads 0x01 two cycles after address=0 is presented. irq stays 0 while global_en=0.
- Edge mode: write MODE=0x01, MASK=0x01, CONTROL=0x1, then pulse irq_in[0] for 1 cycle. irq=1 two cycles after the pulse. Write PENDING=0x01; irq=0 the cycle after the write (holdoff 0).
- Level re-assert: MODE=0, irq_in[0] held high, write PENDING=0x01. The PENDING read still returns 0x01 and irq stays/returns high.
- Priority: MASK=0x0C, SWSET=0x0E. NEXT reads 0x8002. Clear bit 2; NEXT reads 0x8003. Clear bit 3; NEXT reads 0x0000.
- Holdoff: HOLDOFF=10, edge source 0 pending and masked, ack, then re-pulse source 0 at once. irq stays 0 for exactly 10 cycles after the ack, then asserts. CONTROL bit1 reads 1 during the holdoff.
- Set/clear collision: edge rise on source 1 in the same cycle as PENDING write 0x02 leaves bit 1 set. An unmasked-only clear does not start holdoff.
